// File: rtl/ucsbece154b_cache_pkg.sv
// ---------------------------------------------------------------------------
// ucsbece154b_cache_pkg
// Shared definitions for the L1 miss-handling path:
//   - miss_state_e : miss handler FSM states
//   - nr_beats()   : memory beats per cache line
//   - offset_width(): byte-offset bits inside a line
//   - line_align() : clear the byte-offset bits of an address
// Addresses are handled here as up to MAX_ADDR_W bits; callers cast to their
// own address width.
// ---------------------------------------------------------------------------
package ucsbece154b_cache_pkg;

  typedef enum logic [2:0] {
    MS_IDLE,
    MS_PROBE,
    MS_MEM_REQ,
    MS_MEM_WAIT,
    MS_FILL
  } miss_state_e;

  localparam int MAX_ADDR_W = 64;

  function automatic int nr_beats(input int line_w, input int beat_w);
    return line_w / beat_w;
  endfunction

  function automatic int offset_width(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic logic [MAX_ADDR_W-1:0] line_align(
    input logic [MAX_ADDR_W-1:0] addr,
    input int                    off_w
  );
    logic [MAX_ADDR_W-1:0] mask;
    mask = {MAX_ADDR_W{1'b1}} << off_w;
    return addr & mask;
  endfunction

endpackage

// File: rtl/ucsbece154b_line_assembler.sv
// ---------------------------------------------------------------------------
// ucsbece154b_line_assembler
// Collects BEAT_WIDTH-wide memory beats into one LINE_WIDTH line, beat k
// landing in bits [k*BEAT_WIDTH +: BEAT_WIDTH]. The beat counter wraps to 0
// on the last beat so the next line starts from beat 0.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   clear      start a fresh line (counter and line to 0)
//   beat_valid a beat is present on beat_data
//   beat_data  beat payload
//   done       combinational: the current beat is the last of the line
//   line       assembled line register
// ---------------------------------------------------------------------------
module ucsbece154b_line_assembler
  import ucsbece154b_cache_pkg::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  beat_valid,
  input  logic [BEAT_WIDTH-1:0] beat_data,
  output logic                  done,
  output logic [LINE_WIDTH-1:0] line
);

  localparam int NR_BEATS = nr_beats(LINE_WIDTH, BEAT_WIDTH);
  localparam int CNT_W    = (NR_BEATS > 1) ? $clog2(NR_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NR_BEATS - 1);

  logic [CNT_W-1:0] cnt;

  assign done = beat_valid && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt  <= '0;
      line <= '0;
    end else if (beat_valid) begin
      line[cnt*BEAT_WIDTH +: BEAT_WIDTH] <= beat_data;
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ucsbece154b_l1_miss_handler.sv
// ---------------------------------------------------------------------------
// ucsbece154b_l1_miss_handler
// Miss handler between a direct-mapped read-only L1 I-cache, a victim cache
// and the memory port. A miss first probes the victim cache; a hit refills
// L1 from it, otherwise the line is fetched from memory beat by beat. Every
// refill writes the line evicted from L1 (when valid) into the victim cache.
// Ports:
//   clk_i, rst_i              clock, synchronous active-high reset
//   miss_*                    miss request from L1 (ready only in IDLE)
//   evict_*                   line being replaced in L1
//   vc_raddr_o/rdata_i/hit_i  victim cache probe (combinational response)
//   vc_we_o/waddr_o/wdata_o   victim cache write of the evicted line
//   mem_req_*                 line request to memory (valid/ready)
//   mem_rsp_*                 response beats, no backpressure
//   fill_*                    one-cycle L1 fill strobe and payload
// Optional (macro UCSBECE154B_MISS_STATS_EN):
//   vc_hit_cnt_o, mem_refill_cnt_o  saturating event counters
// ADDR_WIDTH must not exceed ucsbece154b_cache_pkg::MAX_ADDR_W.
// ---------------------------------------------------------------------------
module ucsbece154b_l1_miss_handler
  import ucsbece154b_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 56,
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  miss_valid_i,
  output logic                  miss_ready_o,
  input  logic [ADDR_WIDTH-1:0] miss_addr_i,
  input  logic                  evict_valid_i,
  input  logic [ADDR_WIDTH-1:0] evict_addr_i,
  input  logic [LINE_WIDTH-1:0] evict_data_i,
  output logic [ADDR_WIDTH-1:0] vc_raddr_o,
  input  logic [LINE_WIDTH-1:0] vc_rdata_i,
  input  logic                  vc_hit_i,
  output logic                  vc_we_o,
  output logic [ADDR_WIDTH-1:0] vc_waddr_o,
  output logic [LINE_WIDTH-1:0] vc_wdata_o,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_req_addr_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [BEAT_WIDTH-1:0] mem_rsp_data_i,
  output logic                  fill_valid_o,
  output logic [ADDR_WIDTH-1:0] fill_addr_o,
  output logic [LINE_WIDTH-1:0] fill_data_o,
  output logic                  fill_from_vc_o
`ifdef UCSBECE154B_MISS_STATS_EN
  ,
  output logic [31:0]           vc_hit_cnt_o,
  output logic [31:0]           mem_refill_cnt_o
`endif
);

  localparam int OFFSET_WIDTH = offset_width(LINE_WIDTH);

  miss_state_e           state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  ev_valid_q;
  logic [ADDR_WIDTH-1:0] ev_addr_q;
  logic [LINE_WIDTH-1:0] ev_data_q;
  logic [LINE_WIDTH-1:0] vc_line_q;
  logic                  from_vc_q;
  logic                  accept;
  logic                  beat_valid;
  logic                  asm_done;
  logic [LINE_WIDTH-1:0] asm_line;
  logic [ADDR_WIDTH-1:0] miss_line_addr;

  assign accept         = (state == MS_IDLE) && miss_valid_i;
  assign beat_valid     = (state == MS_MEM_WAIT) && mem_rsp_valid_i;
  assign miss_line_addr = ADDR_WIDTH'(line_align(MAX_ADDR_W'(miss_addr_i), OFFSET_WIDTH));

  // The probe, request and fill addresses are all the latched miss line.
  assign vc_raddr_o     = addr_q;
  assign mem_req_addr_o = addr_q;
  assign fill_addr_o    = addr_q;
  assign vc_waddr_o     = ev_addr_q;
  assign vc_wdata_o     = ev_data_q;
  assign fill_from_vc_o = from_vc_q;
  assign fill_data_o    = from_vc_q ? vc_line_q : asm_line;

  ucsbece154b_line_assembler #(
    .LINE_WIDTH(LINE_WIDTH),
    .BEAT_WIDTH(BEAT_WIDTH)
  ) u_line_assembler (
    .clk       (clk_i),
    .rst       (rst_i),
    .clear     (accept),
    .beat_valid(beat_valid),
    .beat_data (mem_rsp_data_i),
    .done      (asm_done),
    .line      (asm_line)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state           <= MS_IDLE;
      miss_ready_o    <= 1'b1;
      mem_req_valid_o <= 1'b0;
      fill_valid_o    <= 1'b0;
      vc_we_o         <= 1'b0;
      addr_q          <= '0;
      ev_valid_q      <= 1'b0;
      ev_addr_q       <= '0;
      ev_data_q       <= '0;
      vc_line_q       <= '0;
      from_vc_q       <= 1'b0;
    end else begin
      unique case (state)
        MS_IDLE: begin
          if (accept) begin
            addr_q       <= miss_line_addr;
            ev_valid_q   <= evict_valid_i;
            ev_addr_q    <= evict_addr_i;
            ev_data_q    <= evict_data_i;
            from_vc_q    <= 1'b0;
            miss_ready_o <= 1'b0;
            state        <= MS_PROBE;
          end
        end
        MS_PROBE: begin
          if (vc_hit_i) begin
            vc_line_q    <= vc_rdata_i;
            from_vc_q    <= 1'b1;
            fill_valid_o <= 1'b1;
            vc_we_o      <= ev_valid_q;
            state        <= MS_FILL;
          end else begin
            mem_req_valid_o <= 1'b1;
            state           <= MS_MEM_REQ;
          end
        end
        MS_MEM_REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= MS_MEM_WAIT;
          end
        end
        MS_MEM_WAIT: begin
          if (asm_done) begin
            fill_valid_o <= 1'b1;
            vc_we_o      <= ev_valid_q;
            state        <= MS_FILL;
          end
        end
        MS_FILL: begin
          fill_valid_o <= 1'b0;
          vc_we_o      <= 1'b0;
          from_vc_q    <= 1'b0;
          miss_ready_o <= 1'b1;
          state        <= MS_IDLE;
        end
        default: state <= MS_IDLE;
      endcase
    end
  end

`ifdef UCSBECE154B_MISS_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vc_hit_cnt_o     <= '0;
      mem_refill_cnt_o <= '0;
    end else begin
      if (state == MS_PROBE && vc_hit_i)
        vc_hit_cnt_o <= sat_inc(vc_hit_cnt_o);
      if (state == MS_FILL && !from_vc_q)
        mem_refill_cnt_o <= sat_inc(mem_refill_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_ucsbece154b_l1_miss_handler.sv
// ---------------------------------------------------------------------------
// Testbench for ucsbece154b_l1_miss_handler (LINE 128, BEAT 32, ADDR 56).
// Each miss is driven by run_miss, which records what the handler did; the
// scenario tasks compare those observations against values computed from
// the transaction itself (aligned address, beat list, evict latch, latency).
// ---------------------------------------------------------------------------
module tb_ucsbece154b_l1_miss_handler;

  localparam int AW = 56;
  localparam int LW = 128;
  localparam int BW = 32;
  localparam int NB = LW / BW;
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(LW / 8 - 1);

  logic          clk;
  logic          rst;
  logic          miss_valid;
  logic          miss_ready;
  logic [AW-1:0] miss_addr;
  logic          evict_valid;
  logic [AW-1:0] evict_addr;
  logic [LW-1:0] evict_data;
  logic [AW-1:0] vc_raddr;
  logic [LW-1:0] vc_rdata;
  logic          vc_hit;
  logic          vc_we;
  logic [AW-1:0] vc_waddr;
  logic [LW-1:0] vc_wdata;
  logic          mem_req_valid;
  logic          mem_req_ready;
  logic [AW-1:0] mem_req_addr;
  logic          mem_rsp_valid;
  logic [BW-1:0] mem_rsp_data;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic [LW-1:0] fill_data;
  logic          fill_from_vc;
`ifdef UCSBECE154B_MISS_STATS_EN
  logic [31:0]   vc_hit_cnt;
  logic [31:0]   mem_refill_cnt;
`endif

  ucsbece154b_l1_miss_handler #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .BEAT_WIDTH(BW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .miss_valid_i   (miss_valid),
    .miss_ready_o   (miss_ready),
    .miss_addr_i    (miss_addr),
    .evict_valid_i  (evict_valid),
    .evict_addr_i   (evict_addr),
    .evict_data_i   (evict_data),
    .vc_raddr_o     (vc_raddr),
    .vc_rdata_i     (vc_rdata),
    .vc_hit_i       (vc_hit),
    .vc_we_o        (vc_we),
    .vc_waddr_o     (vc_waddr),
    .vc_wdata_o     (vc_wdata),
    .mem_req_valid_o(mem_req_valid),
    .mem_req_ready_i(mem_req_ready),
    .mem_req_addr_o (mem_req_addr),
    .mem_rsp_valid_i(mem_rsp_valid),
    .mem_rsp_data_i (mem_rsp_data),
    .fill_valid_o   (fill_valid),
    .fill_addr_o    (fill_addr),
    .fill_data_o    (fill_data),
    .fill_from_vc_o (fill_from_vc)
`ifdef UCSBECE154B_MISS_STATS_EN
    ,
    .vc_hit_cnt_o    (vc_hit_cnt),
    .mem_refill_cnt_o(mem_refill_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference counts of completed victim-cache and memory refills.
  int model_vc_hits  = 0;
  int model_mem_fill = 0;

  // Beats memory will return for the next memory refill.
  logic [BW-1:0] beat_q [NB];

  // Observations of the last run_miss.
  int            obs_fill_cnt;
  int            obs_fill_cyc;
  logic [AW-1:0] obs_fill_addr;
  logic [LW-1:0] obs_fill_data;
  logic          obs_fill_vc;
  logic          obs_we;
  logic [AW-1:0] obs_waddr;
  logic [LW-1:0] obs_wdata;
  logic          obs_saw_req;
  logic [AW-1:0] obs_req_addr;
  logic          obs_req_unstable;
  logic [AW-1:0] obs_probe_addr;
  int            obs_last_beat_cyc;
  logic          obs_ready_after;
  int            obs_stray_we;
  logic          obs_timeout;

  function automatic logic [LW-1:0] expected_mem_line();
    logic [LW-1:0] l;
    l = '0;
    for (int k = 0; k < NB; k++) l[k*BW +: BW] = beat_q[k];
    return l;
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    miss_valid    = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    vc_hit        = 1'b0;
  endtask

  // Drives one miss from acceptance to the IDLE cycle after the fill. Cycle 0
  // is the accept cycle; observations are taken 1 time unit after each edge.
  task automatic run_miss(
    input logic [AW-1:0] addr,
    input logic          ev_v,
    input logic [AW-1:0] ev_a,
    input logic [LW-1:0] ev_d,
    input logic          hit,
    input logic [LW-1:0] vdata,
    input int            req_delay,
    input logic [31:0]   gap_mask,
    input logic          noise
  );
    int   req_wait, sent, widx;
    logic in_wait, hs, done, v;
    obs_fill_cnt = 0; obs_fill_cyc = -1; obs_last_beat_cyc = -1;
    obs_saw_req = 0; obs_req_unstable = 0; obs_stray_we = 0;
    obs_timeout = 0; obs_ready_after = 0; obs_we = 0;
    obs_req_addr = '0; obs_probe_addr = '0;
    miss_valid = 1'b1; miss_addr = addr;
    evict_valid = ev_v; evict_addr = ev_a; evict_data = ev_d;
    vc_hit = hit; vc_rdata = vdata;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(posedge clk); #1;
    miss_valid = 1'b0;
    // Evict inputs change after acceptance; the handler must use its latch.
    evict_valid = ~ev_v; evict_addr = AW'($urandom()); evict_data = rand_line();
    req_wait = 0; sent = 0; widx = 0; in_wait = 0; done = 0;
    for (int n = 1; n < 300; n++) begin
      if (n == 1) obs_probe_addr = vc_raddr;
      if (mem_req_valid) begin
        if (!obs_saw_req) obs_req_addr = mem_req_addr;
        else if (mem_req_addr !== obs_req_addr) obs_req_unstable = 1;
        obs_saw_req = 1;
      end
      if (vc_we && !fill_valid) obs_stray_we++;
      if (obs_fill_cnt > 0 && n == obs_fill_cyc + 1) begin
        obs_ready_after = miss_ready;
        done = 1;
      end
      if (fill_valid) begin
        if (obs_fill_cnt == 0) begin
          obs_fill_cyc  = n;
          obs_fill_addr = fill_addr;
          obs_fill_data = fill_data;
          obs_fill_vc   = fill_from_vc;
          obs_we        = vc_we;
          obs_waddr     = vc_waddr;
          obs_wdata     = vc_wdata;
        end
        obs_fill_cnt++;
      end
      if (done) break;
      if (n >= 2) begin
        vc_hit = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        vc_rdata = rand_line();
      end
      if (noise && obs_fill_cnt == 0) begin
        miss_valid = 1'($urandom_range(0, 1));
        miss_addr  = AW'({$urandom(), $urandom()});
      end else begin
        miss_valid = 1'b0;
      end
      hs = 0;
      if (mem_req_valid && !in_wait) begin
        if (req_wait >= req_delay) begin
          mem_req_ready = 1'b1; hs = 1;
        end else begin
          mem_req_ready = 1'b0; req_wait++;
        end
      end else begin
        mem_req_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      if (in_wait && sent < NB) begin
        v = (widx >= 32) ? 1'b1 : gap_mask[widx];
        widx++;
        mem_rsp_valid = v;
        mem_rsp_data  = v ? beat_q[sent] : $urandom();
        if (v) begin
          sent++;
          if (sent == NB) obs_last_beat_cyc = n;
        end
      end else begin
        mem_rsp_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rsp_data  = $urandom();
      end
      in_wait = in_wait || hs;
      @(posedge clk); #1;
    end
    if (!done) obs_timeout = 1;
    else if (hit) model_vc_hits++;
    else model_mem_fill++;
    idle_inputs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    miss_addr = '0; evict_valid = 0; evict_addr = '0; evict_data = '0;
    vc_rdata = '0; mem_rsp_data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (miss_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b expected 1", miss_ready);
    end
    n_cmp++;
    if ({mem_req_valid, fill_valid, vc_we, fill_from_vc} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 0000",
               {mem_req_valid, fill_valid, vc_we, fill_from_vc});
    end
    n_cmp++;
    if ({vc_raddr, mem_req_addr, fill_addr, vc_waddr} !== '0) begin
      n_fail++;
      $display("FAIL reset_addrs: got %h %h %h %h expected all 0",
               vc_raddr, mem_req_addr, fill_addr, vc_waddr);
    end
    n_cmp++;
    if ({fill_data, vc_wdata} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h expected 0", fill_data, vc_wdata);
    end
  endtask

  task automatic test_vc_hit();
    logic [LW-1:0] aa;
    aa = {(LW / 8){8'hAA}};
    run_miss(AW'(56'h1040), 1'b0, '0, '0, 1'b1, aa, 0, '1, 1'b0);
    n_cmp++;
    if (obs_timeout || obs_fill_cyc != 2) begin
      n_fail++; $display("FAIL vc_hit_latency: got cycle %0d expected 2", obs_fill_cyc);
    end
    n_cmp++;
    if (obs_probe_addr !== AW'(56'h1040)) begin
      n_fail++; $display("FAIL vc_hit_probe_addr: got %h expected 1040", obs_probe_addr);
    end
    n_cmp++;
    if (obs_fill_addr !== AW'(56'h1040) || obs_fill_vc !== 1'b1 || obs_fill_data !== aa) begin
      n_fail++;
      $display("FAIL vc_hit_fill: got addr %h vc %b data %h expected 1040 1 %h",
               obs_fill_addr, obs_fill_vc, obs_fill_data, aa);
    end
    n_cmp++;
    if (obs_saw_req !== 1'b0 || obs_ready_after !== 1'b1 || obs_fill_cnt != 1) begin
      n_fail++;
      $display("FAIL vc_hit_side: got req %b ready %b fills %0d expected 0 1 1",
               obs_saw_req, obs_ready_after, obs_fill_cnt);
    end
  endtask

  task automatic test_mem_refill();
    logic [LW-1:0] exp;
    beat_q[0] = 32'h11111111; beat_q[1] = 32'h22222222;
    beat_q[2] = 32'h33333333; beat_q[3] = 32'h44444444;
    exp = expected_mem_line();
    run_miss(AW'(56'h2008), 1'b0, '0, '0, 1'b0, rand_line(), 3, '1, 1'b0);
    n_cmp++;
    if (obs_req_addr !== AW'(56'h2000) || obs_req_unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_req_addr: got %h unstable %b expected 2000 0",
               obs_req_addr, obs_req_unstable);
    end
    n_cmp++;
    if (obs_fill_data !== 128'h44444444_33333333_22222222_11111111) begin
      n_fail++; $display("FAIL mem_fill_data: got %h expected %h", obs_fill_data, exp);
    end
    n_cmp++;
    if (obs_timeout || obs_fill_cyc != obs_last_beat_cyc + 1) begin
      n_fail++;
      $display("FAIL mem_fill_latency: got cycle %0d expected %0d",
               obs_fill_cyc, obs_last_beat_cyc + 1);
    end
    n_cmp++;
    if (obs_fill_addr !== AW'(56'h2000) || obs_fill_vc !== 1'b0) begin
      n_fail++;
      $display("FAIL mem_fill_addr: got %h vc %b expected 2000 0", obs_fill_addr, obs_fill_vc);
    end
  endtask

  task automatic test_evict();
    logic [LW-1:0] d5;
    d5 = {(LW / 8){8'h5A}};
    run_miss(AW'(56'h4010), 1'b1, AW'(56'h3000), d5, 1'b1, rand_line(), 0, '1, 1'b0);
    n_cmp++;
    if (obs_we !== 1'b1 || obs_waddr !== AW'(56'h3000) || obs_wdata !== d5) begin
      n_fail++;
      $display("FAIL evict_write: got we %b addr %h data %h expected 1 3000 %h",
               obs_we, obs_waddr, obs_wdata, d5);
    end
    run_miss(AW'(56'h4020), 1'b0, AW'(56'h3000), d5, 1'b1, rand_line(), 0, '1, 1'b0);
    n_cmp++;
    if (obs_we !== 1'b0 || obs_stray_we != 0) begin
      n_fail++;
      $display("FAIL evict_none: got we %b stray %0d expected 0 0", obs_we, obs_stray_we);
    end
    // Evicted line at the same address as the miss is still written.
    for (int k = 0; k < NB; k++) beat_q[k] = $urandom();
    run_miss(AW'(56'h3004), 1'b1, AW'(56'h3000), d5, 1'b0, rand_line(), 1, '1, 1'b0);
    n_cmp++;
    if (obs_we !== 1'b1 || obs_waddr !== AW'(56'h3000) || obs_fill_data !== expected_mem_line()) begin
      n_fail++;
      $display("FAIL evict_same_addr: got we %b addr %h data %h expected 1 3000 %h",
               obs_we, obs_waddr, obs_fill_data, expected_mem_line());
    end
  endtask

  task automatic test_gapped();
    for (int k = 0; k < NB; k++) beat_q[k] = 32'hB0000000 | k;
    // Stray beats while idle must not advance the beat counter.
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = $urandom();
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b0;
    run_miss(AW'(56'h5030), 1'b0, '0, '0, 1'b0, rand_line(), 0, 32'h0000_0059, 1'b0);
    n_cmp++;
    if (obs_fill_data !== expected_mem_line()) begin
      n_fail++;
      $display("FAIL gapped_data: got %h expected %h", obs_fill_data, expected_mem_line());
    end
    n_cmp++;
    if (obs_timeout || obs_fill_cyc != obs_last_beat_cyc + 1) begin
      n_fail++;
      $display("FAIL gapped_latency: got %0d expected %0d", obs_fill_cyc, obs_last_beat_cyc + 1);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    miss_valid = 1'b1; miss_addr = AW'(56'h6040); vc_hit = 1'b0;
    evict_valid = 1'b1; evict_addr = AW'(56'h7000); evict_data = rand_line();
    @(posedge clk); #1;
    miss_valid = 1'b0;
    guard = 0;
    while (!mem_req_valid && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    n_cmp++;
    if (!mem_req_valid) begin
      n_fail++; $display("FAIL rstmid_req: got valid %b expected 1", mem_req_valid);
    end
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      mem_rsp_valid = 1'b1; mem_rsp_data = 32'hDEAD0000 | i;
      @(posedge clk); #1;
    end
    mem_rsp_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_vc_hits = 0; model_mem_fill = 0;
    n_cmp++;
    if (miss_ready !== 1'b1 || {mem_req_valid, fill_valid, vc_we} !== 3'b0 || fill_addr !== '0) begin
      n_fail++;
      $display("FAIL rstmid_idle: got ready %b valids %b addr %h expected 1 000 0",
               miss_ready, {mem_req_valid, fill_valid, vc_we}, fill_addr);
    end
    for (int k = 0; k < NB; k++) beat_q[k] = 32'hC0DE0000 | k;
    run_miss(AW'(56'h6080), 1'b0, '0, '0, 1'b0, rand_line(), 0, '1, 1'b0);
    n_cmp++;
    if (obs_fill_data !== expected_mem_line() || obs_fill_addr !== AW'(56'h6080)) begin
      n_fail++;
      $display("FAIL rstmid_fresh: got %h @%h expected %h @6080",
               obs_fill_data, obs_fill_addr, expected_mem_line());
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] a, ea;
    logic [LW-1:0] ed, vd, exp_data;
    logic          ev, h;
    int            bad;
    for (int t = 0; t < 40; t++) begin
      a  = AW'({$urandom(), $urandom()});
      ev = 1'($urandom_range(0, 1));
      ea = ($urandom_range(0, 3) == 0) ? (a & ALIGN_MASK) : AW'({$urandom(), $urandom()});
      ed = rand_line();
      vd = rand_line();
      h  = 1'($urandom_range(0, 1));
      for (int k = 0; k < NB; k++) beat_q[k] = $urandom();
      exp_data = h ? vd : expected_mem_line();
      run_miss(a, ev, ea, ed, h, vd, $urandom_range(0, 4), $urandom(), 1'b1);
      bad = 0;
      if (obs_timeout || obs_fill_cnt != 1 || obs_ready_after !== 1'b1) bad |= 1;
      if (obs_fill_addr !== (a & ALIGN_MASK) || obs_fill_data !== exp_data || obs_fill_vc !== h) bad |= 2;
      if (obs_we !== ev || (ev && (obs_waddr !== ea || obs_wdata !== ed)) || obs_stray_we != 0) bad |= 4;
      if (h && (obs_fill_cyc != 2 || obs_saw_req)) bad |= 8;
      if (!h && (obs_fill_cyc != obs_last_beat_cyc + 1 || obs_req_addr !== (a & ALIGN_MASK) || obs_req_unstable)) bad |= 16;
      if (obs_probe_addr !== (a & ALIGN_MASK)) bad |= 32;
      n_cmp++;
      if (bad != 0) begin
        n_fail++;
        $display("FAIL random_txn%0d: got code %0d fill %h@%h cyc %0d expected code 0 fill %h@%h",
                 t, bad, obs_fill_data, obs_fill_addr, obs_fill_cyc, exp_data, a & ALIGN_MASK);
      end
    end
  endtask

`ifdef UCSBECE154B_MISS_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_vc_hits = 0; model_mem_fill = 0;
    for (int i = 0; i < 3; i++)
      run_miss(AW'(56'h8000) + AW'(i * 64), 1'b0, '0, '0, 1'b1, rand_line(), 0, '1, 1'b0);
    for (int i = 0; i < 2; i++)
      run_miss(AW'(56'h9000) + AW'(i * 64), 1'b1, AW'(56'hA000), rand_line(), 1'b0, rand_line(), 1, '1, 1'b0);
    n_cmp++;
    if (vc_hit_cnt !== 32'(model_vc_hits) || vc_hit_cnt !== 32'd3) begin
      n_fail++; $display("FAIL stats_vc: got %0d expected %0d", vc_hit_cnt, model_vc_hits);
    end
    n_cmp++;
    if (mem_refill_cnt !== 32'(model_mem_fill) || mem_refill_cnt !== 32'd2) begin
      n_fail++; $display("FAIL stats_mem: got %0d expected %0d", mem_refill_cnt, model_mem_fill);
    end
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_vc_hit();
    test_mem_refill();
    test_evict();
    test_gapped();
    test_reset_mid();
    test_random();
`ifdef UCSBECE154B_MISS_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ucsbece154b_l1_miss_handler.md
Name: ucsbece154b_l1_miss_handler

Overview:
- Miss-handling stage placed directly upstream of the victim cache.
- Sits between a direct-mapped, read-only L1 instruction cache and the memory port.
- On an L1 miss it first probes the victim cache. On a victim hit it refills L1 from there; otherwise it fetches the line from memory in BEAT_WIDTH beats.
- In every refill it writes the line evicted from L1 into the victim cache.

Parameters:
ADDR_WIDTH, 56, byte address width
LINE_WIDTH, 128, cache line width in bits; must be a multiple of BEAT_WIDTH
BEAT_WIDTH, 32, memory response beat width in bits

Ports:
clk_i  in  1  single clock
rst_i  in  1  reset; synchronous, active-high
miss_valid_i  in  1  L1 reports a miss
miss_ready_o  out  1  handler can accept a miss (high only in IDLE)
miss_addr_i  in  ADDR_WIDTH  missing byte address
evict_valid_i  in  1  the L1 line being replaced holds valid data
evict_addr_i  in  ADDR_WIDTH  line address of the evicted line
evict_data_i  in  LINE_WIDTH  evicted line data
vc_raddr_o  out  ADDR_WIDTH  victim cache probe address
vc_rdata_i  in  LINE_WIDTH  victim cache read data (combinational)
vc_hit_i  in  1  victim cache hit (combinational)
vc_we_o  out  1  victim cache write enable
vc_waddr_o  out  ADDR_WIDTH  victim cache write address
vc_wdata_o  out  LINE_WIDTH  victim cache write data
mem_req_valid_o  out  1  memory line request valid
mem_req_ready_i  in  1  memory accepts the request
mem_req_addr_o  out  ADDR_WIDTH  line-aligned request address
mem_rsp_valid_i  in  1  response beat valid; there is no backpressure on responses
mem_rsp_data_i  in  BEAT_WIDTH  response beat data
fill_valid_o  out  1  one-cycle L1 fill strobe
fill_addr_o  out  ADDR_WIDTH  line-aligned fill address
fill_data_o  out  LINE_WIDTH  fill line data
fill_from_vc_o  out  1  fill was sourced from the victim cache

Behaviour:
- Constants:
  - NR_BEATS = LINE_WIDTH/BEAT_WIDTH.
  - OFFSET_WIDTH = $clog2(LINE_WIDTH/8).
  - Line alignment zeroes addr[OFFSET_WIDTH-1:0].
- FSM states: IDLE, PROBE, MEM_REQ, MEM_WAIT, FILL.
- Reset (rst_i high at a clock edge):
  - State goes to IDLE; beat counter and all latches clear.
  - Outputs: miss_ready_o=1; all valid/we/fill outputs 0; data/address outputs 0.
- IDLE:
  - On miss_valid_i & miss_ready_o, latch miss_addr_i (line-aligned), evict_valid_i, evict_addr_i and evict_data_i, then go to PROBE.
- PROBE (one cycle):
  - vc_raddr_o = latched address.
  - If vc_hit_i: latch vc_rdata_i, set the from-vc flag, go to FILL.
  - Otherwise go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid_o=1, with mem_req_addr_o held stable until the handshake.
  - On mem_req_ready_i, go to MEM_WAIT with the beat counter at 0.
- MEM_WAIT:
  - Each mem_rsp_valid_i cycle writes beat k into line bits [k*BEAT_WIDTH +: BEAT_WIDTH] and increments k.
  - After beat NR_BEATS-1, go to FILL.
  - The counter width is $clog2(NR_BEATS), minimum 1; it wraps to 0 on entry to FILL.
- FILL (one cycle):
  - fill_valid_o=1 with fill_addr_o, fill_data_o and fill_from_vc_o.
  - If the latched evict_valid is set, assert vc_we_o with the latched evict address and data in the same cycle.
  - Next state is IDLE.
- Latency:
  - Victim-cache hit: miss accepted at cycle 0, PROBE at cycle 1, fill at cycle 2, miss_ready_o high again at cycle 3.
  - Memory refill: fill occurs one cycle after the last beat.
- Outputs when inactive: vc_we_o is asserted only in FILL; mem_req_valid_o only in MEM_REQ.
- Boundary conditions:
  - mem_rsp_valid_i outside MEM_WAIT is ignored.
  - miss_valid_i outside IDLE is ignored; the L1 holds it.
  - A victim-cache hit entry is not invalidated. The resulting duplicate is harmless because L1 is read-only.
  - An evicted line whose address equals the miss address is still written.
  - Reset mid-operation abandons the transaction and drops mem_req_valid_o the next cycle. The memory side is reset together with this block.
  - NR_BEATS=1 is supported: MEM_WAIT lasts exactly one beat.

Optional Feature:
- Macro: UCSBECE154B_MISS_STATS_EN.
- When defined:
  - Adds outputs vc_hit_cnt_o [31:0] and mem_refill_cnt_o [31:0], each a saturating counter.
  - vc_hit_cnt_o increments on a PROBE victim-cache hit; mem_refill_cnt_o increments on a FILL that is not from the victim cache.
  - Both clear on rst_i.
- When undefined: neither port nor the counters exist.

Decomposition:
- Package ucsbece154b_cache_pkg: miss FSM state enum, NR_BEATS and OFFSET_WIDTH helper functions, and a line-align function.
- Sub-module ucsbece154b_line_assembler: beat counter plus line register; ports clear/beat_valid/beat_data/done/line.

Test Plan (LINE 128, BEAT 32):
- Victim-cache hit: miss at 0x1040, vc_hit_i=1, vc_rdata=0xAA..AA -> fill_valid_o at cycle 2, fill_addr_o 0x1040, fill_from_vc_o=1, no mem_req_valid_o.
- Memory refill: miss at 0x2008, vc_hit_i=0, ready after 3 cycles, beats 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> mem_req_addr_o 0x2000; fill_data_o 0x44444444_33333333_22222222_11111111 one cycle after the last beat.
- Eviction write: evict_valid_i=1, evict_addr_i 0x3000, evict_data_i 0x5A..5A -> vc_we_o=1 in the FILL cycle with that address and data; with evict_valid_i=0, vc_we_o stays 0.
- Gapped beats: rsp_valid pattern 1,0,0,1,1,0,1 -> exactly four beats captured in order; stray beats while IDLE are ignored.
- Reset during MEM_WAIT after 2 beats -> next cycle IDLE, miss_ready_o=1, all valid outputs 0; the next miss assembles a fresh line.
- Stats: with UCSBECE154B_MISS_STATS_EN defined, 3 victim-cache hits and 2 memory refills -> vc_hit_cnt_o=3, mem_refill_cnt_o=2.
